// File: rtl/rollo_support_sampler_if.sv
// ---------------------------------------------------------------------------
// rollo_support_sampler_if
//   Bundles the streams and register-file bus around the support sampler.
//
//   Handshake rule for every stream here (basis, rand): a beat transfers on a
//   rising clk edge where valid and ready are both high. A source holds valid
//   and its payload until the transfer happens; valid never waits on ready.
//   The out stream has no ready: the consumer takes every out_valid beat.
//
//   Signals
//     basis_valid/basis_data/basis_ready : basis words, one per beat
//     rand_valid/rand_in/rand_ready      : R-bit random masks
//     out_valid/out_data                 : emitted combination words
//     rf_rw/rf_addr/rf_data_in           : register file write port
//     rf_ctrl_w                          : {accumulate, mask} to the file
//     rf_data_out                        : registered file output
//
//   Modports
//     master : the sampler side
//     slave  : the environment (upstream sources, register file, consumer)
// ---------------------------------------------------------------------------
interface rollo_support_sampler_if #(
    parameter int M = 83,
    parameter int R = 5
);
    localparam int AW = $clog2(R);

    logic          basis_valid;
    logic [M-1:0]  basis_data;
    logic          basis_ready;

    logic          rand_valid;
    logic [R-1:0]  rand_in;
    logic          rand_ready;

    logic          out_valid;
    logic [M-1:0]  out_data;

    logic          rf_rw;
    logic [R:0]    rf_ctrl_w;
    logic [AW-1:0] rf_addr;
    logic [M-1:0]  rf_data_in;
    logic [M-1:0]  rf_data_out;

    modport master (
        input  basis_valid, basis_data, rand_valid, rand_in, rf_data_out,
        output basis_ready, rand_ready, out_valid, out_data,
               rf_rw, rf_ctrl_w, rf_addr, rf_data_in
    );

    modport slave (
        output basis_valid, basis_data, rand_valid, rand_in, rf_data_out,
        input  basis_ready, rand_ready, out_valid, out_data,
               rf_rw, rf_ctrl_w, rf_addr, rf_data_in
    );
endinterface

// File: rtl/rollo_support_sampler.sv
// ---------------------------------------------------------------------------
// rollo_support_sampler
//   Sequencer for the 5-word support register file of the ROLLO encrypt
//   datapath. LOAD writes an R-word basis into the file; GEN then feeds N
//   random R-bit masks to the file's accumulate mode so that every emitted
//   word is a GF(2) combination of the basis. Mask bit R-1-i selects the
//   basis word written i-th during LOAD.
//
//   Ports
//     clk, rst_b  : clock, asynchronous active-low reset
//     start       : run request, only honoured in IDLE
//     reuse       : with start, skip LOAD and keep the current basis
//     busy        : any state other than IDLE
//     done        : pulse with the N-th out_valid
//     dbg_state   : FSM state (0 IDLE, 1 LOAD, 2 GEN, 3 DRAIN)
//     dbg_iss_cnt : masks issued to the file this run
//     dbg_out_cnt : combinations emitted this run
//     bus         : streams and register-file bus (master side)
//
//   R must be 5: the register file accumulate chain is fixed at 5 words.
// ---------------------------------------------------------------------------
module rollo_support_sampler #(
    parameter int N           = 189,
    parameter int M           = 83,
    parameter int R           = 5,
    parameter bit REJECT_ZERO = 1'b1,
    localparam int CW         = $clog2(N + 1),
    localparam int AW         = $clog2(R)
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         start,
    input  logic                         reuse,
    output logic                         busy,
    output logic                         done,
    output logic [1:0]                   dbg_state,
    output logic [CW-1:0]                dbg_iss_cnt,
    output logic [CW-1:0]                dbg_out_cnt,
    rollo_support_sampler_if.master      bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        GEN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [CW-1:0] N_C    = CW'(N);
    localparam logic [CW-1:0] N_LAST = CW'(N - 1);
    localparam logic [AW-1:0] R_LAST = AW'(R - 1);

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] load_cnt;
    logic [CW-1:0] iss_cnt;
    logic [CW-1:0] out_cnt;
    logic [R:0]    ctrl_q;
    logic          out_valid_q;

    logic          basis_fire;
    logic          rand_ok;
    logic          issue;
    logic          clear_cnt;
    logic          out_last;

    // The N-th output: out_cnt still holds N-1 while that beat is on the bus.
    assign out_last = out_valid_q && (out_cnt == N_LAST);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        clear_cnt       = 1'b0;
        basis_fire      = 1'b0;
        rand_ok         = 1'b0;
        issue           = 1'b0;
        bus.basis_ready = 1'b0;
        bus.rand_ready  = 1'b0;
        bus.rf_rw       = 1'b0;
        bus.rf_addr     = '0;
        bus.rf_data_in  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear_cnt = 1'b1;
                    state_nx  = reuse ? GEN : LOAD;
                end
            end
            LOAD: begin
                bus.basis_ready = 1'b1;
                if (bus.basis_valid) begin
                    // Write lands at this edge, so drive the port straight
                    // from the incoming beat.
                    basis_fire     = 1'b1;
                    bus.rf_rw      = 1'b1;
                    bus.rf_addr    = load_cnt;
                    bus.rf_data_in = bus.basis_data;
                    if (load_cnt == R_LAST) begin
                        clear_cnt = 1'b1;
                        state_nx  = GEN;
                    end
                end
            end
            GEN: begin
                rand_ok        = (iss_cnt < N_C);
                bus.rand_ready = rand_ok;
                // A zero mask is still consumed; it just never reaches the file.
                if (rand_ok && bus.rand_valid) begin
                    issue = (|bus.rand_in) || !REJECT_ZERO;
                    if (issue && (iss_cnt == N_LAST)) begin
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_last) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            load_cnt    <= '0;
            iss_cnt     <= '0;
            out_cnt     <= '0;
            ctrl_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (clear_cnt) begin
                load_cnt <= '0;
                iss_cnt  <= '0;
                out_cnt  <= '0;
            end else begin
                if (basis_fire) begin
                    load_cnt <= load_cnt + 1'b1;
                end
                if (issue) begin
                    iss_cnt <= iss_cnt + 1'b1;
                end
                if (out_valid_q) begin
                    out_cnt <= out_cnt + 1'b1;
                end
            end
            ctrl_q      <= issue ? {1'b1, bus.rand_in} : '0;
            // The file captures during the ctrl cycle; its result shows one
            // cycle later, so out_valid trails the accumulate flag by one.
            out_valid_q <= ctrl_q[R];
        end
    end

    assign bus.rf_ctrl_w = ctrl_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = bus.rf_data_out;

    assign busy        = (state != IDLE);
    assign done        = out_last;
    assign dbg_state   = state;
    assign dbg_iss_cnt = iss_cnt;
    assign dbg_out_cnt = out_cnt;

endmodule

// File: doc/rollo_support_sampler.md
# rollo_support_sampler

Sequencer for the 5-word support register file in the ROLLO encrypt datapath. It loads an r-word basis of the secret support from an upstream stream into the register file. It then draws n random r-bit masks from the RNG and drives the register file's accumulate mode so that each emitted m-bit word is a GF(2)-linear combination of the basis. Its output feeds the sparse-vector coefficient builder.

## Interface
- N, `N (189): number of combinations emitted per run
- M, `M (83): word width in bits
- R, `R (5): basis size; the register file accumulate chain is fixed at 5 words, so R must be 5
- REJECT_ZERO, 1: when 1, an all-zero mask is consumed and discarded, with no issue
- clk  in  1  clock
- rst_b  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- reuse  in  1  sampled with start; 1 skips LOAD and keeps the current basis
- basis_valid  in  1  basis beat valid
- basis_data  in  M  basis word
- basis_ready  out  1  high in LOAD only
- rand_valid  in  1  mask valid
- rand_in  in  R  random mask
- rand_ready  out  1  high in GEN while issued count < N
- out_valid  out  1  out_data holds a combination
- out_data  out  M  combination word, passthrough of rf_data_out
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse, coincident with the N-th out_valid
- rf_rw  out  1  register file write enable
- rf_ctrl_w  out  R+1  {accumulate, mask} to the register file; registered
- rf_addr  out  CLOG2(R)  register file write address
- rf_data_in  out  M  register file write data
- rf_data_out  in  M  register file output (registered inside the file)

## Operation
- States: IDLE, LOAD, GEN, DRAIN.
- IDLE:
  - start=1 with reuse=0 goes to LOAD.
  - start=1 with reuse=1 goes to GEN.
  - start is ignored in every other state.
- LOAD:
  - basis_ready=1.
  - Each beat accepted (basis_valid & basis_ready) drives combinationally, in the same cycle: rf_rw=1, rf_addr=load_cnt, rf_data_in=basis_data. The write lands at that edge.
  - load_cnt counts 0..R-1. After beat R-1 is accepted, go to GEN with load_cnt cleared.
  - rf_ctrl_w[R]=0 throughout LOAD.
- GEN:
  - rand_ready = (iss_cnt < N).
  - A mask accepted at edge t with a nonzero value, or with REJECT_ZERO=0, sets rf_ctrl_w = {1, rand_in} for cycle t+1 and increments iss_cnt.
  - Otherwise rf_ctrl_w = {0, 0}.
  - A rejected zero mask is consumed (rand_ready stays high) and does not count.
  - Once iss_cnt reaches N, go to DRAIN.
- DRAIN: wait until out_cnt = N, then go to IDLE.
- Mask mapping: mask bit R-1-i selects basis word i, where i is the beat order in LOAD. out_data = XOR of the selected words. An all-zero mask gives 0.
- rf_rw=0 outside LOAD. rf_addr and rf_data_in hold 0 when not writing.
- out_valid is a two-stage delay of the issue event. out_cnt counts out_valid cycles. done is asserted with the out_valid on which out_cnt reaches N.
- There is no output backpressure: the consumer must accept every out_valid.
- Counters:
  - load_cnt is CLOG2(R) bits.
  - iss_cnt and out_cnt are CLOG2(N+1) bits.
  - All counters are cleared on entry to LOAD or GEN.
  - No counter wraps.

## Timing
- Reset (asynchronous, any state): state=IDLE, all counters 0, and every output 0: basis_ready, rand_ready, out_valid, done, busy, rf_rw, rf_ctrl_w, rf_addr, rf_data_in. A run in progress is abandoned; the register file is reset by the same rst_b.
- start at edge t: busy=1 from cycle t+1.
- LOAD lasts at least R cycles; each basis_valid gap adds one cycle.
- Issue-to-output latency is 2 cycles:
  - mask accepted at edge t
  - ctrl word driven in cycle t+1
  - register file captures at the end of t+1
  - out_valid in cycle t+2
- With continuous rand_valid, GEN issues one mask per cycle; each rand gap adds one cycle.
- Minimum run from start: R + N + 3 cycles. With reuse: N + 3.
- In the cycle after done, state=IDLE and busy=0. A start in that cycle is accepted.

## Test plan
- Reset, then load basis 1,2,4,8,16; N=3; masks 5'b10000, 5'b00001, 5'b10101 -> out_data 1, 16, 21 on three consecutive cycles, done with the third, busy=0 the next cycle.
- Same basis; mask 5'b11111 -> out_data 31. With basis_valid deasserted every other beat, LOAD takes 9 cycles and rf_addr sequences 0..4.
- REJECT_ZERO=1: masks 0, 0, 5'b01000 -> rand_ready stays high, only one issue, out_data 2, iss_cnt=1.
- reuse=1 start after a completed run -> basis_ready stays 0, no rf_rw pulse, outputs use the previous basis (mask 5'b00100 -> 4).
- rand_valid stalled for 3 cycles mid-GEN -> out_valid gaps match exactly; out_cnt and done still reach N correctly.
- rst_b asserted mid-GEN after 2 issues -> all outputs 0 immediately, state IDLE; a new start runs a clean full load.
